// File: rtl/usb_packet_receiver.sv
// Host-side USB packet receiver: PID decode, DATA0/DATA1 payload capture,
// CRC16 residue check, data-toggle check and response timeout.
//
// state   | meaning
// IDLE    | waiting for rx_start
// ARMED   | response timer running, waiting for first bit
// PID     | shifting in the 8 PID bits
// HS_END  | handshake PID received, waiting for eop
// PAYLOAD | capturing data bytes and CRC16
// DRAIN   | bad packet, discarding bits until eop
// DONE    | data packet result cycle
module usb_packet_receiver #(
    parameter int MAX_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           rx_start,
    input  logic                           bit_in,
    input  logic                           bit_valid,
    input  logic                           eop,
    input  logic                           expected_toggle,
    output logic                           busy,
    output logic                           rec_ACK,
    output logic                           rec_NAK,
    output logic                           rec_STALL,
    output logic                           rec_DATA,
    output logic                           data_pid1,
    output logic                           data_valid,
    output logic                           crc_error,
    output logic                           pid_error,
    output logic                           seq_error,
    output logic                           overflow,
    output logic                           timeout,
    output logic [$clog2(MAX_BYTES+1)-1:0] byte_count,
    output logic [8*MAX_BYTES-1:0]         data_out
);

    localparam int NBITS = (MAX_BYTES + 2) * 8;
    localparam int DW    = 8 * MAX_BYTES;
    localparam int CW    = $clog2(NBITS + 1);
    localparam int BCW   = $clog2(MAX_BYTES + 1);
    localparam int TW    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, ARMED, PID, HS_END, PAYLOAD, DRAIN, DONE
    } state_t;

    state_t             state;
    logic [TW-1:0]      timer;
    logic [CW-1:0]      bit_cnt;
    logic [7:0]         pid_sr;
    logic [15:0]        crc;
    logic [NBITS-1:0]   buf_q;
    logic               exp_tog;
    logic               ovf_q;

    logic [7:0]         pid_next;
    logic [15:0]        crc_next;
    logic               fb;
    logic [CW-1:0]      shift_amt;
    logic [DW-1:0]      aligned;
    logic [CW-4:0]      bytes_rx;
    logic [BCW-1:0]     count_next;
    logic [DW-1:0]      data_next;
    logic               crc_bad;
    logic               seq_bad;

    assign busy = (state != IDLE);

    always_comb begin
        pid_next   = {bit_in, pid_sr[7:1]};
        fb         = bit_in ^ crc[15];
        crc_next   = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        bytes_rx   = bit_cnt[CW-1:3];
        // Bits enter at the top of buf_q, so shift the received bits down to bit 0.
        shift_amt  = CW'(NBITS) - bit_cnt;
        aligned    = DW'(buf_q >> shift_amt);
        if (ovf_q)
            count_next = BCW'(MAX_BYTES);
        else if (bytes_rx >= (CW-3)'(2))
            count_next = BCW'(bytes_rx - (CW-3)'(2));
        else
            count_next = '0;
        data_next = '0;
        for (int i = 0; i < MAX_BYTES; i++)
            if (i < int'(count_next))
                data_next[8*i +: 8] = aligned[8*i +: 8];
        crc_bad = (crc != 16'h800D) || (bit_cnt[2:0] != 3'd0) || (bytes_rx < (CW-3)'(2));
        seq_bad = (pid_sr[3] != exp_tog);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            bit_cnt    <= '0;
            pid_sr     <= '0;
            crc        <= '0;
            buf_q      <= '0;
            exp_tog    <= 1'b0;
            ovf_q      <= 1'b0;
            rec_ACK    <= 1'b0;
            rec_NAK    <= 1'b0;
            rec_STALL  <= 1'b0;
            rec_DATA   <= 1'b0;
            data_pid1  <= 1'b0;
            data_valid <= 1'b0;
            crc_error  <= 1'b0;
            pid_error  <= 1'b0;
            seq_error  <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            byte_count <= '0;
            data_out   <= '0;
        end else begin
            rec_ACK    <= 1'b0;
            rec_NAK    <= 1'b0;
            rec_STALL  <= 1'b0;
            rec_DATA   <= 1'b0;
            data_valid <= 1'b0;
            crc_error  <= 1'b0;
            pid_error  <= 1'b0;
            seq_error  <= 1'b0;
            overflow   <= 1'b0;
            timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_start) begin
                        exp_tog <= expected_toggle;
                        timer   <= TW'(TIMEOUT_CYCLES - 1);
                        state   <= ARMED;
                    end
                end
                ARMED: begin
                    if (bit_valid) begin
                        pid_sr  <= pid_next;
                        bit_cnt <= CW'(1);
                        state   <= PID;
                    end else if (eop) begin
                        pid_error <= 1'b1;
                        state     <= IDLE;
                    end else if (timer == '0) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                PID: begin
                    if (bit_valid) begin
                        pid_sr <= pid_next;
                        if (bit_cnt == CW'(7)) begin
                            bit_cnt <= '0;
                            crc     <= 16'hFFFF;
                            ovf_q   <= 1'b0;
                            if (pid_next[7:4] != ~pid_next[3:0]) begin
                                pid_error <= 1'b1;
                                state     <= DRAIN;
                            end else begin
                                case (pid_next[3:0])
                                    4'b0010, 4'b1010, 4'b1110: state <= HS_END;
                                    4'b0011, 4'b1011:          state <= PAYLOAD;
                                    default: begin
                                        pid_error <= 1'b1;
                                        state     <= DRAIN;
                                    end
                                endcase
                            end
                        end else begin
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end else if (eop) begin
                        pid_error <= 1'b1;
                        state     <= IDLE;
                    end
                end
                HS_END: begin
                    if (bit_valid) begin
                        pid_error <= 1'b1;
                        state     <= DRAIN;
                    end else if (eop) begin
                        rec_ACK   <= (pid_sr[3:0] == 4'b0010);
                        rec_NAK   <= (pid_sr[3:0] == 4'b1010);
                        rec_STALL <= (pid_sr[3:0] == 4'b1110);
                        state     <= IDLE;
                    end
                end
                PAYLOAD: begin
                    if (bit_valid) begin
                        crc <= crc_next;
                        if (bit_cnt < CW'(NBITS)) begin
                            buf_q   <= {bit_in, buf_q[NBITS-1:1]};
                            bit_cnt <= bit_cnt + CW'(1);
                        end else if (!ovf_q) begin
                            ovf_q    <= 1'b1;
                            overflow <= 1'b1;
                        end
                    end else if (eop) begin
                        // Results are registered here so they appear the cycle after eop.
                        rec_DATA   <= 1'b1;
                        data_pid1  <= pid_sr[3];
                        byte_count <= count_next;
                        data_out   <= data_next;
                        crc_error  <= crc_bad;
                        seq_error  <= seq_bad;
                        data_valid <= !crc_bad && !ovf_q && !seq_bad;
                        state      <= DONE;
                    end
                end
                DRAIN: begin
                    if (eop)
                        state <= IDLE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_packet_receiver.sv
// Directed bench for usb_packet_receiver (MAX_BYTES=8, TIMEOUT_CYCLES=255).
// Inputs change on the falling edge; outputs are sampled on the falling edge after each active edge.
module tb_usb_packet_receiver;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_start = 1'b0;
    logic        bit_in = 1'b0;
    logic        bit_valid = 1'b0;
    logic        eop = 1'b0;
    logic        expected_toggle = 1'b0;
    logic        busy, rec_ACK, rec_NAK, rec_STALL, rec_DATA, data_pid1, data_valid;
    logic        crc_error, pid_error, seq_error, overflow, timeout;
    logic [3:0]  byte_count;
    logic [63:0] data_out;

    localparam logic [9:0] P_ACK = 10'h200, P_NAK = 10'h100, P_STALL = 10'h080,
                           P_DATA = 10'h040, P_DV = 10'h020, P_CRC = 10'h010,
                           P_PID = 10'h008, P_SEQ = 10'h004, P_OVF = 10'h002,
                           P_TMO = 10'h001;

    int         n_tests = 0;
    int         n_fail = 0;
    int         ovf_seen = 0;
    logic [9:0] pulse_acc = '0;
    logic [7:0] pl [16];
    logic [7:0] hs_pid [3];
    logic [9:0] hs_exp [3];
    logic [7:0] pidv;

    usb_packet_receiver #(.MAX_BYTES(8), .TIMEOUT_CYCLES(255)) dut (
        .clock(clock), .reset_n(reset_n), .rx_start(rx_start), .bit_in(bit_in),
        .bit_valid(bit_valid), .eop(eop), .expected_toggle(expected_toggle),
        .busy(busy), .rec_ACK(rec_ACK), .rec_NAK(rec_NAK), .rec_STALL(rec_STALL),
        .rec_DATA(rec_DATA), .data_pid1(data_pid1), .data_valid(data_valid),
        .crc_error(crc_error), .pid_error(pid_error), .seq_error(seq_error),
        .overflow(overflow), .timeout(timeout), .byte_count(byte_count),
        .data_out(data_out)
    );

    always #5 clock = ~clock;

    function automatic logic [9:0] pulses();
        return {rec_ACK, rec_NAK, rec_STALL, rec_DATA, data_valid,
                crc_error, pid_error, seq_error, overflow, timeout};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        bit_valid = 1'b1;
        bit_in    = b;
        tick();
        bit_valid = 1'b0;
        if (overflow) ovf_seen++;
        pulse_acc |= pulses();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_eop();
        eop = 1'b1;
        tick();
        eop = 1'b0;
    endtask

    task automatic start(input logic tog);
        expected_toggle = tog;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
    endtask

    // Sends pid, pl[0..n-1] and the inverted CRC16 MSB first; flip inverts bit 0 of that byte after CRC.
    task automatic send_data(input logic [7:0] pid, input int n, input int flip);
        logic [15:0] crc;
        logic        fb;
        logic [7:0]  v;
        send_byte(pid);
        crc = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            v = pl[i];
            for (int j = 0; j < 8; j++) begin
                fb  = v[j] ^ crc[15];
                crc = {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
            if (i == flip) v[0] = ~v[0];
            send_byte(v);
        end
        for (int j = 15; j >= 0; j--) send_bit(~crc[j]);
    endtask

    initial begin
        hs_pid = '{8'hD2, 8'h5A, 8'h1E};
        hs_exp = '{P_ACK, P_NAK, P_STALL};
        tick();
        tick();
        check("reset_pulses", pulses(), 0);
        check("reset_busy", busy, 0);
        check("reset_count", byte_count, 0);
        check("reset_data", data_out, 0);
        check("reset_pid1", data_pid1, 0);
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < 3; k++) begin
            start(1'b0);
            check("hs_busy_armed", busy, 1);
            send_byte(hs_pid[k]);
            check("hs_no_early_pulse", pulses(), 0);
            send_eop();
            check("hs_pulse", pulses(), hs_exp[k]);
            check("hs_busy_fall", busy, 0);
            tick();
            check("hs_pulse_width", pulses(), 0);
        end

        for (int i = 0; i < 8; i++) pl[i] = 8'(i + 1);
        start(1'b0);
        send_data(8'hC3, 8, -1);
        send_eop();
        check("d0_pulses", pulses(), P_DATA | P_DV);
        check("d0_count", byte_count, 8);
        check("d0_data", data_out, 64'h0807060504030201);
        check("d0_pid1", data_pid1, 0);
        check("d0_busy_done", busy, 1);
        tick();
        check("d0_pulse_width", pulses(), 0);
        check("d0_busy_fall", busy, 0);
        check("d0_hold", data_out, 64'h0807060504030201);

        start(1'b0);
        send_data(8'hC3, 8, 3);
        send_eop();
        check("flip_pulses", pulses(), P_DATA | P_CRC);
        check("flip_count", byte_count, 8);
        check("flip_data", data_out, 64'h0807060505030201);
        tick();

        start(1'b0);
        expected_toggle = 1'b1;
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
        send_data(8'h4B, 0, -1);
        send_eop();
        check("d1_seq_pulses", pulses(), P_DATA | P_SEQ);
        check("d1_seq_pid1", data_pid1, 1);
        check("d1_seq_count", byte_count, 0);
        check("d1_seq_data", data_out, 0);
        tick();

        pl[0] = 8'hAA; pl[1] = 8'hBB; pl[2] = 8'hCC;
        start(1'b1);
        send_data(8'h4B, 3, -1);
        send_eop();
        check("d1_ok_pulses", pulses(), P_DATA | P_DV);
        check("d1_ok_count", byte_count, 3);
        check("d1_ok_data", data_out, 64'h0000000000CCBBAA);
        check("d1_ok_pid1", data_pid1, 1);
        tick();

        start(1'b0);
        for (int k = 1; k <= 254; k++) tick();
        check("tmo_not_early", timeout, 0);
        check("tmo_busy_254", busy, 1);
        tick();
        check("tmo_pulse", pulses(), P_TMO);
        check("tmo_idle", busy, 0);
        tick();
        check("tmo_width", timeout, 0);

        start(1'b0);
        for (int k = 1; k <= 254; k++) tick();
        pidv = 8'hD2;
        send_bit(pidv[0]);
        check("tmo_bit_wins", timeout, 0);
        check("tmo_bit_busy", busy, 1);
        for (int i = 1; i < 8; i++) send_bit(pidv[i]);
        send_eop();
        check("tmo_bit_ack", pulses(), P_ACK);
        tick();

        start(1'b0);
        send_byte(8'hD3);
        check("badpid_pulse", pulses(), P_PID);
        send_byte(8'h55);
        check("drain_quiet", pulses(), 0);
        send_eop();
        check("drain_eop_quiet", pulses(), 0);
        check("drain_idle", busy, 0);

        start(1'b0);
        send_byte(8'hD2);
        send_bit(1'b1);
        check("hs_extra_bit", pulses(), P_PID);
        send_eop();
        check("hs_extra_idle", busy, 0);
        tick();

        for (int i = 0; i < 12; i++) pl[i] = 8'(8'h11 + i);
        start(1'b0);
        ovf_seen = 0;
        send_byte(8'hC3);
        for (int i = 0; i < 12; i++) send_byte(pl[i]);
        check("ovf_once", ovf_seen, 1);
        send_eop();
        check("ovf_pulses", pulses() & ~P_CRC, P_DATA);
        check("ovf_count", byte_count, 8);
        check("ovf_data", data_out, 64'h1817161514131211);
        tick();

        start(1'b0);
        send_byte(8'hC3);
        send_byte(8'h21);
        send_byte(8'h22);
        reset_n = 1'b0;
        #1;
        check("rst_mid_pulses", pulses(), 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", byte_count, 0);
        check("rst_mid_data", data_out, 0);
        tick();
        reset_n = 1'b1;
        pulse_acc = '0;
        send_byte(8'h23);
        send_byte(8'h24);
        send_eop();
        pulse_acc |= pulses();
        tick();
        pulse_acc |= pulses();
        check("rst_rest_quiet", pulse_acc, 0);
        check("rst_rest_idle", busy, 0);
        check("rst_rest_data", data_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
